// File: rtl/test_split_ram.sv
// Split-transaction single-port RAM target: programmable ack wait states, byte-enabled
// writes, and in-order read responses after a fixed pipelined latency.
`timescale 1ns/1ps
module test_split_ram #(
  parameter int MEM_WORDS_POW = 10,
  parameter int RD_LAT        = 2,
  parameter int ACK_WAIT      = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        host_req,
  output logic        host_ack,
  input  logic        host_we,
  input  logic [31:0] host_addr,
  input  logic [31:0] host_wdata,
  input  logic [3:0]  host_be,
  output logic        host_resp,
  output logic [31:0] host_rdata
);
  localparam int         WORDS    = 1 << MEM_WORDS_POW;
  localparam logic [3:0] WAIT_CNT = 4'(ACK_WAIT);

  typedef enum logic {IDLE, STALL} state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       ack_int;
  logic       wr_hs, rd_hs;

  logic [MEM_WORDS_POW-1:0] idx;
  logic [31:0]              mem [WORDS];

  logic        vld_p [RD_LAT];
  logic [31:0] dat_p [RD_LAT];

  // Byte-offset bits and bits above the word index are don't-care; upper addresses alias.
  logic unused_addr;
  assign unused_addr = ^{host_addr[31:MEM_WORDS_POW+2], host_addr[1:0]};
  assign idx         = host_addr[MEM_WORDS_POW+1:2];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ack_int   = 1'b0;
    case (state)
      IDLE: begin
        if (host_req) begin
          if (ACK_WAIT == 0) begin
            ack_int = 1'b1;
          end else begin
            cnt_nxt   = 4'd1;
            state_nxt = STALL;
          end
        end
      end
      STALL: begin
        ack_int = host_req && (cnt == WAIT_CNT);
        // A dropped request is tolerated: abandon the wait and start over.
        if (!host_req || ack_int) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  assign host_ack = rst_i && ack_int;
  assign wr_hs    = host_req && host_ack && host_we;
  assign rd_hs    = host_req && host_ack && !host_we;

  // Storage is never reset so contents survive a mid-run reset.
  always_ff @(posedge clk_i) begin
    if (wr_hs) begin
      for (int b = 0; b < 4; b++) begin
        if (host_be[b]) mem[idx][8*b +: 8] <= host_wdata[8*b +: 8];
      end
    end
  end

  // Stage p0 captures the read word; stages p1..p(RD_LAT-1) only delay it.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int s = 0; s < RD_LAT; s++) begin
        vld_p[s] <= 1'b0;
        dat_p[s] <= '0;
      end
    end else begin
      vld_p[0] <= rd_hs;
      dat_p[0] <= rd_hs ? mem[idx] : '0;
      for (int s = 1; s < RD_LAT; s++) begin
        vld_p[s] <= vld_p[s-1];
        dat_p[s] <= dat_p[s-1];
      end
    end
  end

  assign host_resp  = vld_p[RD_LAT-1];
  assign host_rdata = dat_p[RD_LAT-1];

endmodule

// File: tb/tb_test_split_ram.sv
// Bench for test_split_ram: three configurations driven by directed and random
// transactions, checked every cycle against a cycle-timeline reference model.
`timescale 1ns/1ps
module tb_test_split_ram;
  localparam int NI = 3;
  localparam int TL = 8192;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0]       rstn, req, we, ack, resp;
  logic [NI-1:0][31:0] addr, wdata, rdata;
  logic [NI-1:0][3:0]  be;

  test_split_ram #(.MEM_WORDS_POW(4), .RD_LAT(2), .ACK_WAIT(0)) u_dut0 (
    .clk_i(clk), .rst_i(rstn[0]), .host_req(req[0]), .host_ack(ack[0]), .host_we(we[0]),
    .host_addr(addr[0]), .host_wdata(wdata[0]), .host_be(be[0]),
    .host_resp(resp[0]), .host_rdata(rdata[0]));
  test_split_ram #(.MEM_WORDS_POW(10), .RD_LAT(4), .ACK_WAIT(0)) u_dut1 (
    .clk_i(clk), .rst_i(rstn[1]), .host_req(req[1]), .host_ack(ack[1]), .host_we(we[1]),
    .host_addr(addr[1]), .host_wdata(wdata[1]), .host_be(be[1]),
    .host_resp(resp[1]), .host_rdata(rdata[1]));
  test_split_ram #(.MEM_WORDS_POW(6), .RD_LAT(1), .ACK_WAIT(3)) u_dut2 (
    .clk_i(clk), .rst_i(rstn[2]), .host_req(req[2]), .host_ack(ack[2]), .host_we(we[2]),
    .host_addr(addr[2]), .host_wdata(wdata[2]), .host_be(be[2]),
    .host_resp(resp[2]), .host_rdata(rdata[2]));

  int          vectors, miscompares, cyc;
  int          waited [NI];
  bit          got_hs [NI];
  int          hs_cyc [NI];
  int          last_cyc [NI];
  int          resp_cnt [NI];
  logic [31:0] last_rd [NI];
  logic [31:0] mem_m [NI][1024];
  bit          exp_vld [NI][TL];
  logic [31:0] exp_dat [NI][TL];
  logic [31:0] rlog [$];
  int          rcyc [$];

  function automatic int lat_of(input int i);
    case (i) 0: return 2; 1: return 4; default: return 1; endcase
  endfunction
  function automatic int wait_of(input int i);
    case (i) 0: return 0; 1: return 0; default: return 3; endcase
  endfunction
  function automatic int pow_of(input int i);
    case (i) 0: return 4; 1: return 10; default: return 6; endcase
  endfunction

  task automatic chk(input int i, input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s[%0d] cycle %0d: observed %h expected %h", tag, i, cyc, obs, exp);
    end
  endtask

  // Reference model: a request is acked once it has been pending ACK_WAIT cycles;
  // a read handshake in cycle c schedules its data for cycle c + RD_LAT.
  task automatic step(input int i);
    logic        a_exp;
    int          idx;
    int          due;
    got_hs[i] = 1'b0;
    if (!rstn[i]) begin
      chk(i, "ack_in_reset",   ack[i],   32'd0);
      chk(i, "resp_in_reset",  resp[i],  32'd0);
      chk(i, "rdata_in_reset", rdata[i], 32'd0);
      for (int c = cyc; c < TL; c++) exp_vld[i][c] = 1'b0;
      waited[i] = 0;
    end else begin
      a_exp = req[i] && (waited[i] == wait_of(i));
      chk(i, "ack",   ack[i],   a_exp);
      chk(i, "resp",  resp[i],  exp_vld[i][cyc]);
      chk(i, "rdata", rdata[i], exp_vld[i][cyc] ? exp_dat[i][cyc] : 32'd0);
      if (resp[i] === 1'b1) begin
        last_rd[i]  = rdata[i];
        last_cyc[i] = cyc;
        resp_cnt[i]++;
        if (i == 1) begin
          rlog.push_back(rdata[i]);
          rcyc.push_back(cyc);
        end
      end
      got_hs[i] = req[i] && (ack[i] === 1'b1);
      if (got_hs[i]) hs_cyc[i] = cyc;
      if (a_exp) begin
        idx = int'((addr[i] >> 2) & ((32'd1 << pow_of(i)) - 32'd1));
        if (we[i]) begin
          for (int b = 0; b < 4; b++)
            if (be[i][b]) mem_m[i][idx][8*b +: 8] = wdata[i][8*b +: 8];
        end else begin
          due = cyc + lat_of(i);
          exp_vld[i][due] = 1'b1;
          exp_dat[i][due] = mem_m[i][idx];
        end
        waited[i] = 0;
      end else if (req[i]) begin
        waited[i]++;
      end else begin
        waited[i] = 0;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < NI; i++) step(i);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    req = '0;
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic xfer(input int i, input bit w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] e, output int n);
    req[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = d; be[i] = e;
    n = 0;
    do begin
      tick();
      n++;
    end while (!got_hs[i] && n < 40);
    chk(i, "handshake", got_hs[i], 32'd1);
  endtask

  initial begin
    int          n, rc, h0, wd;
    logic [31:0] a;
    vectors = 0; miscompares = 0; cyc = 0;
    rstn = '0; req = '0; we = '0; addr = '0; wdata = '0; be = '0;
    for (int i = 0; i < NI; i++) begin
      waited[i] = 0; resp_cnt[i] = 0; last_rd[i] = '0; hs_cyc[i] = 0; last_cyc[i] = 0;
    end
    tick();
    tick();
    rstn = '1;
    idle(2);

    // Preload words 0..15 of every instance; instance 1 words 0..3 hold 0xA0..0xA3.
    for (int i = 0; i < NI; i++)
      for (int w = 0; w < 16; w++)
        xfer(i, 1'b1, 32'(w << 2), (i == 1 && w < 4) ? 32'hA0 + 32'(w) : $urandom, 4'hF, n);
    idle(2);

    // Write then immediate read, zero wait states.
    xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, n);
    chk(0, "wr_ack_cycles", n, 32'd1);
    xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, n);
    chk(0, "rd_ack_cycles", n, 32'd1);
    idle(4);
    chk(0, "raw_data", last_rd[0], 32'hDEADBEEF);
    chk(0, "rd_latency", last_cyc[0] - hs_cyc[0], 32'd2);

    // Byte-enable merge.
    xfer(0, 1'b1, 32'h20, 32'h11223344, 4'hF, n);
    xfer(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'h5, n);
    xfer(0, 1'b0, 32'h20, 32'h0, 4'h0, n);
    idle(4);
    chk(0, "byte_enable", last_rd[0], 32'h11BB33DD);

    // Aliasing: 0x40 maps to word 0 with a 16-word RAM.
    xfer(0, 1'b1, 32'h0, 32'h5, 4'hF, n);
    xfer(0, 1'b0, 32'h40, 32'h0, 4'hF, n);
    idle(4);
    chk(0, "alias", last_rd[0], 32'h5);

    // Reset one cycle after a read handshake, held for two cycles.
    xfer(0, 1'b1, 32'h30, 32'hCAFEF00D, 4'hF, n);
    xfer(0, 1'b0, 32'h30, 32'h0, 4'hF, n);
    req[0] = 1'b0;
    rc = resp_cnt[0];
    rstn[0] = 1'b0;
    tick();
    tick();
    rstn[0] = 1'b1;
    idle(5);
    chk(0, "no_resp_after_reset", resp_cnt[0], rc);
    xfer(0, 1'b0, 32'h30, 32'h0, 4'hF, n);
    idle(3);
    chk(0, "ram_kept_over_reset", last_rd[0], 32'hCAFEF00D);

    // Four back-to-back reads with RD_LAT = 4.
    rlog.delete();
    rcyc.delete();
    h0 = 0;
    for (int w = 0; w < 4; w++) begin
      xfer(1, 1'b0, 32'(w << 2), 32'h0, 4'hF, n);
      if (w == 0) h0 = hs_cyc[1];
    end
    idle(6);
    chk(1, "burst_count", rlog.size(), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < rlog.size()) begin
        chk(1, "burst_data", rlog[k], 32'hA0 + 32'(k));
        chk(1, "burst_cycle", rcyc[k], 32'(h0 + 4 + k));
      end
    end

    // ACK_WAIT = 3: ack on the 4th cycle of each held request.
    xfer(2, 1'b0, 32'h8, 32'h0, 4'hF, n);
    chk(2, "ack_wait_first", n, 32'd4);
    xfer(2, 1'b0, 32'hC, 32'h0, 4'hF, n);
    chk(2, "ack_wait_second", n, 32'd4);
    idle(3);

    // Randomized traffic over the preloaded words, with aliased upper address bits.
    for (int i = 0; i < NI; i++) begin
      for (int k = 0; k < 80; k++) begin
        wd = $urandom_range(0, 15);
        a  = ($urandom << (pow_of(i) + 2)) | 32'(wd << 2) | 32'($urandom_range(0, 3));
        xfer(i, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), n);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
      idle(6);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/test_split_ram.md
# test_split_ram

Split-transaction single-port RAM target for the test harness. It sits directly downstream of the split-transaction delayer and consumes its target-side request/response bus. It accepts requests after a programmable number of ack wait states, performs byte-enabled writes, and returns read data in order after a fixed pipelined latency. It is the memory model behind delayed-bus core testbenches.

## Interface
- MEM_WORDS_POW, 10: RAM depth is 2^MEM_WORDS_POW 32-bit words; legal range 4..16.
- RD_LAT, 2: read response latency in cycles from the request handshake; legal range 1..8.
- ACK_WAIT, 0: number of stall cycles a pending request sees before ack; legal range 0..15.
- clk_i  in  1  clock; all state changes on its rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- host_req  in  1  request valid; held by the master until acked.
- host_ack  out  1  request accepted this cycle.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  32  byte address.
- host_wdata  in  32  write data.
- host_be  in  4  byte enables; bit n qualifies wdata[8n+7:8n].
- host_resp  out  1  read response valid, one cycle per read.
- host_rdata  out  32  read data; 0 when host_resp = 0.

## Operation
- A handshake occurs in any cycle with host_req && host_ack. Request fields are sampled only in that cycle.
- Word index is host_addr[MEM_WORDS_POW+1:2]. host_addr[1:0] and the bits above the index are ignored, so higher addresses alias.
- Ack control is a two-state FSM with a 4-bit wait counter cnt:
  - IDLE (cnt = 0): if host_req and ACK_WAIT = 0, host_ack = 1 combinationally this cycle and the FSM stays in IDLE. If host_req and ACK_WAIT > 0, host_ack = 0, cnt becomes 1 and the FSM moves to STALL.
  - STALL: host_ack = host_req && (cnt == ACK_WAIT). If not acked and host_req is still 1, cnt increments. On a handshake, or if host_req drops (protocol violation, tolerated), cnt returns to 0 and the FSM returns to IDLE.
  - host_ack is never 1 while host_req = 0.
- Write handshake: each byte whose host_be bit is 1 is updated at the end of the handshake cycle; other bytes are kept. A write produces no response. host_be = 0 is a legal no-op.
- Read handshake: the RAM word is read. The response (valid plus data) travels through an RD_LAT-deep shift pipeline.
- Responses are always delivered in request order and never dropped. The response path has no backpressure and needs no FIFO because the pipeline accepts one entry per cycle.
- Read-after-write: a write handshake in cycle T followed by a read of the same word in T+1 returns the written data.
- RAM contents are not cleared by reset and are not initialized. The testbench preloads or writes before reading.

## Timing
- Reset values: host_ack = 0, host_resp = 0, host_rdata = 0, FSM = IDLE, cnt = 0, all pipeline valids = 0.
- While rst_i = 0, host_ack is forced to 0.
- Reset asserted mid-operation: in-flight responses are discarded and no host_resp appears after reset release. RAM contents are preserved.
- Ack latency: a request raised in cycle T is acked in cycle T + ACK_WAIT.
- Read latency: a handshake in cycle T produces host_resp = 1 with host_rdata in cycle T + RD_LAT. Both outputs are registered.
- Throughput: one handshake per cycle when ACK_WAIT = 0. Otherwise at most one handshake per ACK_WAIT+1 cycles for back-to-back requests.
- Back-to-back reads produce back-to-back host_resp pulses with no gap.
- Writes interleaved with reads leave gaps in host_resp only at the write slots.

## Test plan
- ACK_WAIT=0, RD_LAT=2: write 0xDEADBEEF to 0x10 with be=0xF, then read 0x10 in the next cycle. Required: ack in the same cycle as each req, and host_resp=1 with rdata=0xDEADBEEF exactly 2 cycles after the read handshake.
- Byte enables: write 0x11223344 with be=0xF, then 0xAABBCCDD with be=0x5, then read. Required: rdata=0x11BB33DD.
- ACK_WAIT=3: hold req on a read. Required: host_ack=0 for 3 cycles and 1 on the 4th. Two consecutive reads get acks at T+3 and T+7.
- RD_LAT=4: four back-to-back reads of preloaded words 0..3 (values 0xA0..0xA3). Required: four consecutive host_resp cycles starting 4 cycles after the first handshake, carrying data 0xA0, 0xA1, 0xA2, 0xA3 in order.
- Aliasing, MEM_WORDS_POW=4: write 0x5 to address 0x0; read address 0x40. Required: rdata=0x5.
- Reset mid-flight: issue a read, then assert rst_i low 1 cycle later for 2 cycles. Required: host_resp stays 0 through and after reset, and a later read of the same word returns its pre-reset contents.
